// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: shadowed value, prescaled digit scan,
// hex/decimal glyph decode, leading-zero suppression and one dead cycle per slot.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int HEX_MODE   = 0,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic          POL      = (ACTIVE_LOW != 0);
  localparam logic [6:0]    SEG_OFF  = POL ? 7'h7f : 7'h00;
  localparam logic          DP_OFF   = POL;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{POL}};

  logic [PW-1:0]           r_pre;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic [3:0]            w_nib;
  logic                  w_dp_lit;
  logic                  w_zero_sel;
  logic                  w_acc;
  logic [NUM_DIGITS-1:0] w_zero_from;
  logic [NUM_DIGITS-1:0] w_an_hot;
  logic                  w_dead;
  logic                  w_suppress;
  logic [6:0]            w_glyph;
  logic [6:0]            w_seg_nxt;
  logic                  w_dp_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;

  // Active-low glyph for one nibble; 10-15 blank unless HEX_MODE.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    if (HEX_MODE == 0 && nib > 4'd9) g = 7'b1111111;
    return g;
  endfunction

  // w_zero_from[i]: every shadow nibble from i up to the top digit is zero.
  always_comb begin
    w_acc       = 1'b1;
    w_zero_from = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_acc = w_acc & (r_shadow_val[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      w_zero_from[NUM_DIGITS-1-k] = w_acc;
    end
  end

  always_comb begin
    w_nib      = '0;
    w_dp_lit   = 1'b0;
    w_zero_sel = 1'b0;
    w_an_hot   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib       = r_shadow_val[4*i +: 4];
        w_dp_lit    = r_shadow_dp[i];
        w_zero_sel  = w_zero_from[i];
        w_an_hot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_dead     = (r_pre == PRE_LAST);
    w_suppress = blank_lz && (r_idx != '0) && w_zero_sel;
    w_glyph    = w_suppress ? 7'b1111111 : glyph(w_nib);
    w_seg_nxt  = SEG_OFF;
    w_dp_nxt   = DP_OFF;
    w_an_nxt   = AN_OFF;
    if (enable && !w_dead) begin
      w_seg_nxt = POL ? w_glyph : ~w_glyph;
      w_dp_nxt  = POL ? ~w_dp_lit : w_dp_lit;
      w_an_nxt  = POL ? ~w_an_hot : w_an_hot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre        <= '0;
      r_idx        <= '0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_seg        <= SEG_OFF;
      r_dp         <= DP_OFF;
      r_an         <= AN_OFF;
    end else begin
      if (load) begin
        r_shadow_val <= value;
        r_shadow_dp  <= dp_in;
      end
      if (w_dead) begin
        r_pre <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule
